// File: rtl/keypad_decoder_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : keypad_decoder_pkg
// Brief   : Shared key codes, keypad row/column constants and FSM state
//           encoding for the keypad front end.
// Revision: 1.0 - initial release
// ============================================================================
package keypad_decoder_pkg;

    // Decoded key codes
    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    // Row one-hot values (conv8[3:0])
    localparam logic [3:0] ROW_0 = 4'b0001;
    localparam logic [3:0] ROW_1 = 4'b0010;
    localparam logic [3:0] ROW_2 = 4'b0100;
    localparam logic [3:0] ROW_3 = 4'b1000;

    // Column one-hot values (conv8[7:4]); bit 7 is never a legal column
    localparam logic [3:0] COL_0 = 4'b0100;
    localparam logic [3:0] COL_1 = 4'b0010;
    localparam logic [3:0] COL_2 = 4'b0001;

    // Debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } kp_state_e;

endpackage
`default_nettype wire

// File: rtl/keypad_decoder_kp_code_map.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : kp_code_map
// Brief   : Combinational keypad code decoder. Legal codes have exactly one
//           row bit and one of the three column bits set; anything else
//           reports legal=0 and code=KEY_NONE.
// Revision: 1.0 - initial release
// ============================================================================
module kp_code_map (
    input  logic [7:0] conv8,
    output logic       legal,
    output logic [3:0] code
);
    import keypad_decoder_pkg::*;

    // Full-code lookup: a single table covers both legality and mapping
    always_comb begin
        legal = 1'b1;
        code  = KEY_NONE;
        case (conv8)
            {COL_0, ROW_0}: code = KEY_1;
            {COL_1, ROW_0}: code = KEY_2;
            {COL_2, ROW_0}: code = KEY_3;
            {COL_0, ROW_1}: code = KEY_4;
            {COL_1, ROW_1}: code = KEY_5;
            {COL_2, ROW_1}: code = KEY_6;
            {COL_0, ROW_2}: code = KEY_7;
            {COL_1, ROW_2}: code = KEY_8;
            {COL_2, ROW_2}: code = KEY_9;
            {COL_0, ROW_3}: code = KEY_HASH;
            {COL_1, ROW_3}: code = KEY_0;
            {COL_2, ROW_3}: code = KEY_STAR;
            default: begin
                legal = 1'b0;
                code  = KEY_NONE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/keypad_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : keypad_decoder
// Brief   : Synchronises and debounces the raw keypad code and emits one
//           key_valid pulse per physical press. Optional key_err output is
//           enabled by defining KEYPAD_ERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module keypad_decoder #(
    parameter int DEB_PRESS   = 20,
    parameter int DEB_RELEASE = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] conv8,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
`ifdef KEYPAD_ERR_EN
    ,
    output logic       key_err
`endif
);
    import keypad_decoder_pkg::*;

    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(DEB_PRESS - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(DEB_RELEASE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic [7:0]       sync1_q;
    logic [7:0]       s8_q;
    kp_state_e        state_q, state_d;
    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
`ifdef KEYPAD_ERR_EN
    logic             key_err_q, key_err_d;
`endif
    logic             map_legal;
    logic [3:0]       map_code;

    // The candidate only reaches the end of PRESS_WAIT if s8 still equals it,
    // so decoding the candidate is the same as decoding s8 at acceptance.
    kp_code_map u_map (
        .conv8 (cand_q),
        .legal (map_legal),
        .code  (map_code)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Two-flop synchroniser for the asynchronous keypad lines
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 8'h00;
            s8_q    <= 8'h00;
        end else begin
            sync1_q <= conv8;
            s8_q    <= sync1_q;
        end
    end

    // Debounce FSM next-state, counter and registered-output logic
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
`ifdef KEYPAD_ERR_EN
        key_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s8_q != 8'h00) begin
                    state_d = ST_PRESS_WAIT;
                    cand_d  = s8_q;
                end
            end
            ST_PRESS_WAIT: begin
                if (s8_q == cand_q) begin
                    if (cnt_q == PRESS_LAST) begin
                        // Illegal codes still go HELD so they must be released
                        state_d = ST_HELD;
                        if (map_legal) begin
                            key_valid_d = 1'b1;
                            key_code_d  = map_code;
                        end else begin
`ifdef KEYPAD_ERR_EN
                            key_err_d = 1'b1;
`endif
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_HELD: begin
                if (s8_q == 8'h00) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s8_q == 8'h00) begin
                    if (cnt_q == RELEASE_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    // Release bounce: back to HELD without a new pulse
                    state_d = ST_HELD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    // State, counter and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cand_q      <= 8'h00;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_ERR_EN
            key_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_ERR_EN
            key_err_q   <= key_err_d;
`endif
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
`ifdef KEYPAD_ERR_EN
    assign key_err   = key_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_keypad_decoder
// Brief   : Directed self-checking bench for keypad_decoder (10 ns clock,
//           default parameters). Define KEYPAD_ERR_EN to exercise key_err.
// Revision: 1.0 - initial release
// ============================================================================
module tb_keypad_decoder;
    import keypad_decoder_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] conv8 = 8'h00;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_err;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int         cyc = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         n_bad_seq = 0;
    int         last_valid_cyc = -1;
    logic       prev_pulse = 1'b0;
    logic [3:0] codes[$];

    keypad_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .conv8     (conv8),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
`ifdef KEYPAD_ERR_EN
        ,
        .key_err   (key_err)
`endif
    );
`ifndef KEYPAD_ERR_EN
    assign key_err = 1'b0;
`endif

    always #5 clock = ~clock;

    // Count rising edges
    always @(posedge clock) cyc <= cyc + 1;

    // Record pulses on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (key_valid === 1'b1) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            codes.push_back(key_code);
        end
        if (key_err === 1'b1) n_err <= n_err + 1;
        if ((key_valid === 1'b1 && key_err === 1'b1) ||
            (prev_pulse && (key_valid === 1'b1 || key_err === 1'b1)))
            n_bad_seq <= n_bad_seq + 1;
        prev_pulse <= (key_valid === 1'b1) || (key_err === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        int t0, vb;
        reset = 1'b0;
        conv8 = 8'h28;
        #20;
        checks++;
        if ({key_code, key_valid, key_held, key_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {key_code, key_valid, key_held, key_err});
        end
        @(negedge clock);
        reset = 1'b1;
        t0 = cyc;
        vb = n_valid;
        step(22);
        checks++;
        if (n_valid - vb != 0) begin
            errors++;
            $display("FAIL reset_early_pulse: got %0d pulses expected 0", n_valid - vb);
        end
        step(1);
        checks++;
        if (key_valid !== 1'b1 || key_code !== KEY_0 || last_valid_cyc - t0 != 23) begin
            errors++;
            $display("FAIL reset_first_key: valid=%b code=%h lat=%0d expected 1/0/23",
                     key_valid, key_code, last_valid_cyc - t0);
        end
        conv8 = 8'h00;
        step(20);
    endtask

    task automatic test_single_press();
        int t0, vb;
        conv8 = 8'h21;
        t0 = cyc;
        vb = n_valid;
        step(100);
        checks++;
        if (n_valid - vb != 1 || last_valid_cyc - t0 != 23) begin
            errors++;
            $display("FAIL single_count_lat: got %0d pulses lat %0d expected 1 lat 23",
                     n_valid - vb, last_valid_cyc - t0);
        end
        checks++;
        if (key_code !== KEY_2 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL single_code_held: code=%h held=%b expected 2/1", key_code, key_held);
        end
        conv8 = 8'h00;
        step(10);
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL single_held_before_release: got %b expected 1", key_held);
        end
        step(1);
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL single_held_after_release: got %b expected 0", key_held);
        end
        step(10);
    endtask

    task automatic test_bounce();
        int t0, vb;
        vb = n_valid;
        for (int i = 0; i < 6; i++) begin
            conv8 = 8'h42;
            step(5);
            conv8 = 8'h00;
            step(5);
        end
        checks++;
        if (n_valid - vb != 0) begin
            errors++;
            $display("FAIL bounce_no_pulse: got %0d expected 0", n_valid - vb);
        end
        conv8 = 8'h42;
        t0 = cyc;
        step(40);
        checks++;
        if (n_valid - vb != 1 || key_code !== KEY_4 || last_valid_cyc - t0 != 23) begin
            errors++;
            $display("FAIL bounce_steady: pulses=%0d code=%h lat=%0d expected 1/4/23",
                     n_valid - vb, key_code, last_valid_cyc - t0);
        end
        conv8 = 8'h00;
        step(20);
    endtask

    task automatic test_sequence();
        logic [7:0] stim [10];
        logic [3:0] exp  [10];
        int vb, qb;
        stim = '{8'h21, 8'h42, 8'h11, 8'h11, 8'h48, 8'h21, 8'h42, 8'h11, 8'h41, 8'h48};
        exp  = '{4'h2, 4'h4, 4'h3, 4'h3, 4'hB, 4'h2, 4'h4, 4'h3, 4'h1, 4'hB};
        vb = n_valid;
        qb = codes.size();
        for (int i = 0; i < 10; i++) begin
            conv8 = stim[i];
            step(100);
            conv8 = 8'h00;
            step(10);
        end
        step(20);
        checks++;
        if (n_valid - vb != 10) begin
            errors++;
            $display("FAIL seq_count: got %0d expected 10", n_valid - vb);
        end
        for (int i = 0; i < 10; i++) begin
            if (qb + i < codes.size()) begin
                checks++;
                if (codes[qb + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL seq_code[%0d]: got %h expected %h", i, codes[qb + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_map();
        logic [7:0] stim [7];
        logic [3:0] exp  [7];
        int vb;
        stim = '{8'h41, 8'h22, 8'h12, 8'h44, 8'h24, 8'h14, 8'h18};
        exp  = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        for (int i = 0; i < 7; i++) begin
            vb = n_valid;
            conv8 = stim[i];
            step(30);
            checks++;
            if (n_valid - vb != 1 || key_code !== exp[i]) begin
                errors++;
                $display("FAIL map_%h: pulses=%0d code=%h expected 1/%h",
                         stim[i], n_valid - vb, key_code, exp[i]);
            end
            conv8 = 8'h00;
            step(12);
        end
        step(10);
    endtask

    task automatic test_illegal();
        int vb, eb;
        vb = n_valid;
        eb = n_err;
        conv8 = 8'h33;
        step(50);
        checks++;
        if (n_valid - vb != 0 || key_code !== KEY_STAR || key_held !== 1'b1) begin
            errors++;
            $display("FAIL illegal_no_key: pulses=%0d code=%h held=%b expected 0/a/1",
                     n_valid - vb, key_code, key_held);
        end
`ifdef KEYPAD_ERR_EN
        checks++;
        if (n_err - eb != 1) begin
            errors++;
            $display("FAIL illegal_err_pulse: got %0d expected 1", n_err - eb);
        end
`endif
        conv8 = 8'h00;
        step(20);
        checks++;
        if (key_held !== 1'b0 || n_err - eb != n_err - eb + 0 && 1'b0) begin
            errors++;
            $display("FAIL illegal_release: held=%b expected 0", key_held);
        end
    endtask

    task automatic test_reset_mid();
        int vb;
        vb = n_valid;
        conv8 = 8'h21;
        step(13);
        reset = 1'b0;
        #1;
        checks++;
        if ({key_code, key_valid, key_held, key_err} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 0000000",
                     {key_code, key_valid, key_held, key_err});
        end
        conv8 = 8'h00;
        step(2);
        reset = 1'b1;
        step(40);
        checks++;
        if (n_valid - vb != 0) begin
            errors++;
            $display("FAIL mid_reset_discard: got %0d pulses expected 0", n_valid - vb);
        end
        conv8 = 8'h21;
        step(40);
        conv8 = 8'h00;
        step(4);
        conv8 = 8'h21;
        step(40);
        conv8 = 8'h00;
        step(20);
        checks++;
        if (n_valid - vb != 1 || key_code !== KEY_2 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL short_gap_single: pulses=%0d code=%h held=%b expected 1/2/0",
                     n_valid - vb, key_code, key_held);
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (n_bad_seq != 0) begin
            errors++;
            $display("FAIL pulse_rules: got %0d violations expected 0", n_bad_seq);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_sequence();
        test_map();
        test_illegal();
        test_reset_mid();
        test_pulse_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
